mem_access: RTL and testbench

Memory-access stage of the riscv32i pipeline, directly downstream of the execute stage. It takes the execute result (effective address or ALU value), store data, memory enables and func3, and drives a req/ack data bus with byte strobes. Load data is aligned and sign/zero-extended. Registered results go to write-back, and a stall is raised while a bus transaction is outstanding.

---
 rtl/mem_access.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// RV32I memory stage: issues one req/ack bus access per load/store, aligns load data, registers write-back results.
// Latency: non-memory/faulting ops 1 cycle; memory ops ack+1 cycles; mem_stall holds upstream while BUSY.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        reg_enable_in,
  input  logic [31:0] store_data_in,
  input  logic        mem_we_in,
  input  logic        mem_re_in,
  input  logic [2:0]  func3_in,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_enable,
  output logic        mem_fault
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        en_q, en_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic        bwe_q, bwe_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wbv_q, wbv_d;
  logic [31:0] wbd_q, wbd_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic        wben_q, wben_d;
  logic        fault_q, fault_d;

  logic        is_mem;
  logic        bad_op;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  assign is_mem = mem_we_in | mem_re_in;

  always_comb begin
    bad_op = 1'b0;
    if (mem_we_in && mem_re_in) begin
      bad_op = 1'b1;
    end else if (mem_re_in) begin
      bad_op = !(func3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (mem_we_in) begin
      bad_op = !(func3_in inside {3'b000, 3'b001, 3'b010});
    end
    // Size comes from func3[1:0] for both loads and stores.
    if (func3_in[1:0] == 2'b01 && alu_result_in[0]) bad_op = 1'b1;
    if (func3_in[1:0] == 2'b10 && alu_result_in[1:0] != 2'b00) bad_op = 1'b1;
  end

  always_comb begin
    lane_wdata = store_data_in;
    lane_wstrb = 4'b1111;
    case (func3_in[1:0])
      2'b00: begin
        lane_wdata = {4{store_data_in[7:0]}};
        lane_wstrb = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        lane_wdata = {2{store_data_in[15:0]}};
        lane_wstrb = 4'b0011 << {alu_result_in[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign rd_shift = dbus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b101:  load_data = {16'b0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    en_d    = en_q;
    we_d    = we_q;
    req_d   = req_q;
    bwe_d   = bwe_q;
    baddr_d = baddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    wbrd_d  = wbrd_q;
    wben_d  = wben_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wbv_d  = 1'b1;
            wbd_d  = alu_result_in;
            wbrd_d = rd_addr_in;
            wben_d = reg_enable_in;
          end else if (bad_op) begin
            wbv_d   = 1'b1;
            fault_d = 1'b1;
            wbrd_d  = rd_addr_in;
            wben_d  = 1'b0;
          end else begin
            state_d = BUSY;
            cnt_d   = 16'd0;
            addr_d  = alu_result_in;
            f3_d    = func3_in;
            rd_d    = rd_addr_in;
            en_d    = reg_enable_in;
            we_d    = mem_we_in;
            req_d   = 1'b1;
            bwe_d   = mem_we_in;
            baddr_d = {alu_result_in[31:2], 2'b00};
            wdata_d = lane_wdata;
            wstrb_d = mem_we_in ? lane_wstrb : 4'b0000;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        // Ack takes priority over the timeout limit in the same cycle.
        if (dbus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbrd_d  = rd_q;
          wbd_d   = we_q ? addr_q : load_data;
          wben_d  = we_q ? 1'b0 : en_q;
        end else if (cnt_q == LIMIT) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          fault_d = 1'b1;
          wbrd_d  = rd_q;
          wben_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      bwe_q   <= 1'b0;
      baddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wbv_q   <= 1'b0;
      wbd_q   <= '0;
      wbrd_q  <= '0;
      wben_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      en_q    <= en_d;
      we_q    <= we_d;
      req_q   <= req_d;
      bwe_q   <= bwe_d;
      baddr_q <= baddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      wbrd_q  <= wbrd_d;
      wben_q  <= wben_d;
      fault_q <= fault_d;
    end
  end

  assign mem_stall     = (state_q == BUSY);
  assign dbus_req      = req_q;
  assign dbus_we       = bwe_q;
  assign dbus_addr     = baddr_q;
  assign dbus_wdata    = wdata_q;
  assign dbus_wstrb    = wstrb_q;
  assign wb_valid      = wbv_q;
  assign wb_data       = wbd_q;
  assign wb_rd_addr    = wbrd_q;
  assign wb_reg_enable = wben_q;
  assign mem_fault     = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table, hand-written corner sequences, random ops against a reference model.
module tb_mem_access;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_result_in;
  logic [4:0]  rd_addr_in;
  logic        reg_enable_in;
  logic [31:0] store_data_in;
  logic        mem_we_in;
  logic        mem_re_in;
  logic [2:0]  func3_in;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_enable;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result_in(alu_result_in),
    .rd_addr_in(rd_addr_in), .reg_enable_in(reg_enable_in), .store_data_in(store_data_in),
    .mem_we_in(mem_we_in), .mem_re_in(mem_re_in), .func3_in(func3_in),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_reg_enable(wb_reg_enable), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        en;
    logic [31:0] sd;
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [3:0]  ack_k;   // 0 = ack withheld
    logic [31:0] rdata;
    logic        x_fault;
    logic        x_req;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_wstrb;
    logic [31:0] x_wbdata;
    logic        x_wben;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, 32'(dbus_req), 0);
    chk({tag, ".we"}, 32'(dbus_we), 0);
    chk({tag, ".addr"}, dbus_addr, 0);
    chk({tag, ".wdata"}, dbus_wdata, 0);
    chk({tag, ".wstrb"}, 32'(dbus_wstrb), 0);
    chk({tag, ".stall"}, 32'(mem_stall), 0);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".wb_rd"}, 32'(wb_rd_addr), 0);
    chk({tag, ".wb_en"}, 32'(wb_reg_enable), 0);
    chk({tag, ".fault"}, 32'(mem_fault), 0);
  endtask

  // Reference model: derives the expected outcome of one op from the architectural rules.
  function automatic vec_t model(input vec_t v);
    logic        is_mem, ok;
    int unsigned size, off;
    logic [31:0] lane, b, h;
    is_mem = v.we | v.re;
    ok = 1'b1;
    if (v.we && v.re) ok = 1'b0;
    if (v.re && !(v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ok = 1'b0;
    if (v.we && !(v.f3 inside {3'd0, 3'd1, 3'd2})) ok = 1'b0;
    size = 1 << v.f3[1:0];
    if (is_mem && ok && (v.alu % size) != 0) ok = 1'b0;
    off = v.alu % 4;
    v.x_req   = is_mem && ok;
    v.x_fault = is_mem && !ok;
    v.x_addr  = v.x_req ? v.alu - off : 32'd0;
    v.x_wdata = 0;
    v.x_wstrb = 0;
    if (v.x_req && v.we) begin
      case (size)
        1: begin v.x_wdata = (v.sd & 32'hFF) * 32'h01010101; v.x_wstrb = 4'(1 << off); end
        2: begin v.x_wdata = (v.sd & 32'hFFFF) * 32'h00010001; v.x_wstrb = 4'(3 << off); end
        default: begin v.x_wdata = v.sd; v.x_wstrb = 4'd15; end
      endcase
    end
    lane = v.rdata >> (8 * off);
    b = lane & 32'hFF;
    h = lane & 32'hFFFF;
    if (!is_mem || v.we) v.x_wbdata = v.alu;
    else if (v.f3 == 3'd0) v.x_wbdata = (b >= 128) ? b - 32'd256 : b;
    else if (v.f3 == 3'd1) v.x_wbdata = (h >= 32768) ? h - 32'd65536 : h;
    else if (v.f3 == 3'd4) v.x_wbdata = b;
    else if (v.f3 == 3'd5) v.x_wbdata = h;
    else v.x_wbdata = v.rdata;
    if (v.x_req && (v.ack_k == 0 || int'(v.ack_k) > TO)) v.x_fault = 1'b1;
    v.x_wben = (v.x_fault || v.we) ? 1'b0 : v.en;
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    alu_result_in = v.alu;
    rd_addr_in    = v.rd;
    reg_enable_in = v.en;
    store_data_in = v.sd;
    mem_we_in     = v.we;
    mem_re_in     = v.re;
    func3_in      = v.f3;
    in_valid      = 1'b1;
    tick();
    in_valid  = 1'b0;
    mem_we_in = 1'b0;
    mem_re_in = 1'b0;
    if (!v.x_req) begin
      chk({tag, ".wb_valid"}, 32'(wb_valid), 1);
      chk({tag, ".fault"}, 32'(mem_fault), 32'(v.x_fault));
      chk({tag, ".wb_en"}, 32'(wb_reg_enable), 32'(v.x_wben));
      chk({tag, ".noreq"}, 32'(dbus_req), 0);
      chk({tag, ".nostall"}, 32'(mem_stall), 0);
      if (!v.x_fault) begin
        chk({tag, ".wb_data"}, wb_data, v.x_wbdata);
        chk({tag, ".wb_rd"}, 32'(wb_rd_addr), 32'(v.rd));
      end
      return;
    end
    chk({tag, ".req"}, 32'(dbus_req), 1);
    chk({tag, ".stall"}, 32'(mem_stall), 1);
    chk({tag, ".addr"}, dbus_addr, v.x_addr);
    chk({tag, ".we"}, 32'(dbus_we), 32'(v.we));
    chk({tag, ".wstrb"}, 32'(dbus_wstrb), 32'(v.x_wstrb));
    if (v.we) chk({tag, ".wdata"}, dbus_wdata, v.x_wdata);
    for (int c = 1; c <= TO; c++) begin
      if (c == int'(v.ack_k)) begin
        dbus_ack   = 1'b1;
        dbus_rdata = v.rdata;
      end
      tick();
      dbus_ack   = 1'b0;
      dbus_rdata = $urandom;
      if (c == int'(v.ack_k) || c == TO) begin
        chk({tag, ".done_valid"}, 32'(wb_valid), 1);
        chk({tag, ".done_fault"}, 32'(mem_fault), 32'(v.x_fault));
        chk({tag, ".done_req"}, 32'(dbus_req), 0);
        chk({tag, ".done_stall"}, 32'(mem_stall), 0);
        chk({tag, ".done_en"}, 32'(wb_reg_enable), 32'(v.x_wben));
        chk({tag, ".done_rd"}, 32'(wb_rd_addr), 32'(v.rd));
        if (!v.x_fault) chk({tag, ".done_data"}, wb_data, v.x_wbdata);
        return;
      end
      chk({tag, ".wait_valid"}, 32'(wb_valid), 0);
      chk({tag, ".wait_req"}, 32'(dbus_req), 1);
      chk({tag, ".wait_stall"}, 32'(mem_stall), 1);
      chk({tag, ".wait_addr"}, dbus_addr, v.x_addr);
    end
  endtask

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t, expected under 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //          alu           rd   en sd            we re f3      ack rdata          flt req addr          wdata         wstrb    wbdata        wben
    tbl[0]  = '{32'h00001234, 5'd5, 1, 32'h0,        0, 0, 3'b000, 4'd0, 32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 32'h00001234, 1};
    tbl[1]  = '{32'h00000103, 5'd7, 1, 32'h0,        0, 1, 3'b000, 4'd3, 32'h80FF0000, 0, 1, 32'h100,      32'h0,        4'b0000, 32'hFFFFFF80, 1};
    tbl[2]  = '{32'h00000103, 5'd7, 1, 32'h0,        0, 1, 3'b100, 4'd3, 32'h80FF0000, 0, 1, 32'h100,      32'h0,        4'b0000, 32'h00000080, 1};
    tbl[3]  = '{32'h00000022, 5'd9, 1, 32'hDEADBEEF, 1, 0, 3'b001, 4'd1, 32'h0,        0, 1, 32'h20,       32'hBEEFBEEF, 4'b1100, 32'h00000022, 0};
    tbl[4]  = '{32'h00000101, 5'd3, 1, 32'h0,        0, 1, 3'b010, 4'd0, 32'h0,        1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0};
    tbl[5]  = '{32'h00000100, 5'd3, 1, 32'h0,        1, 1, 3'b010, 4'd0, 32'h0,        1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0};
    tbl[6]  = '{32'h00000102, 5'd10,1, 32'h0,        0, 1, 3'b001, 4'd2, 32'h80015678, 0, 1, 32'h100,      32'h0,        4'b0000, 32'hFFFF8001, 1};
    tbl[7]  = '{32'h00000102, 5'd10,1, 32'h0,        0, 1, 3'b101, 4'd2, 32'h80015678, 0, 1, 32'h100,      32'h0,        4'b0000, 32'h00008001, 1};
    tbl[8]  = '{32'h00000013, 5'd11,1, 32'h000000A5, 1, 0, 3'b000, 4'd1, 32'h0,        0, 1, 32'h10,       32'hA5A5A5A5, 4'b1000, 32'h00000013, 0};
    tbl[9]  = '{32'h00000040, 5'd12,1, 32'h12345678, 1, 0, 3'b010, 4'd4, 32'h0,        0, 1, 32'h40,       32'h12345678, 4'b1111, 32'h00000040, 0};
    tbl[10] = '{32'h00000000, 5'd1, 1, 32'h0,        0, 1, 3'b011, 4'd0, 32'h0,        1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0};
    tbl[11] = '{32'h00000000, 5'd1, 1, 32'h0,        1, 0, 3'b100, 4'd0, 32'h0,        1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0};
    tbl[12] = '{32'h00000101, 5'd2, 1, 32'h0,        0, 1, 3'b001, 4'd0, 32'h0,        1, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        0};
    tbl[13] = '{32'h00000204, 5'd6, 1, 32'h0,        0, 1, 3'b010, 4'd2, 32'hCAFEF00D, 0, 1, 32'h204,      32'h0,        4'b0000, 32'hCAFEF00D, 1};
    tbl[14] = '{32'h00000200, 5'd4, 1, 32'h0,        0, 1, 3'b010, 4'd0, 32'h0,        1, 1, 32'h200,      32'h0,        4'b0000, 32'h0,        0};

    rst = 1'b1; in_valid = 1'b0; alu_result_in = 0; rd_addr_in = 0; reg_enable_in = 0;
    store_data_in = 0; mem_we_in = 0; mem_re_in = 0; func3_in = 0; dbus_ack = 0; dbus_rdata = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      do_op(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].x_req && tbl[i].x_fault) begin
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        chk("late_ack.wb_valid", 32'(wb_valid), 0);
        chk("late_ack.fault", 32'(mem_fault), 0);
        chk("late_ack.req", 32'(dbus_req), 0);
      end
      tick();
      chk("idle.wb_valid", 32'(wb_valid), 0);
      chk("idle.fault", 32'(mem_fault), 0);
    end

    // Back-to-back non-memory ops: one result per cycle, never stalled.
    for (int i = 1; i <= 3; i++) begin
      alu_result_in = 32'(i * 32'h111);
      rd_addr_in    = 5'(i);
      reg_enable_in = 1'b1;
      in_valid      = 1'b1;
      tick();
      chk("b2b.wb_valid", 32'(wb_valid), 1);
      chk("b2b.wb_data", wb_data, 32'(i * 32'h111));
      chk("b2b.wb_rd", 32'(wb_rd_addr), 32'(i));
      chk("b2b.stall", 32'(mem_stall), 0);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b.end", 32'(wb_valid), 0);
    chk("b2b.data_hold", wb_data, 32'h333);

    // Reset on the second BUSY cycle discards the load.
    alu_result_in = 32'h300; rd_addr_in = 5'd8; mem_re_in = 1'b1; func3_in = 3'b010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; mem_re_in = 1'b0;
    chk("rstbusy.req1", 32'(dbus_req), 1);
    tick();
    chk("rstbusy.req2", 32'(dbus_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rstbusy");
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    chk("rstbusy.late_ack", 32'(wb_valid), 0);
    chk("rstbusy.late_req", 32'(dbus_req), 0);
    v = tbl[0];
    do_op(v, "post_rst_add");
    tick();

    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 3);
      v = '0;
      v.alu   = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
      v.rd    = 5'($urandom);
      v.en    = 1'($urandom);
      v.sd    = $urandom;
      v.we    = r[0];
      v.re    = r[1];
      v.f3    = 3'($urandom_range(0, 7));
      v.ack_k = 4'($urandom_range(0, 5));
      v.rdata = $urandom;
      v = model(v);
      do_op(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        chk("rnd.idle_ack", 32'(wb_valid), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
